// File: rtl/id_operand_stage.sv
// Decode-stage slot: buffers the IF instruction, resolves operands from the register file or bypass,
// and freezes them once EX back-pressures so EX sees stable values at issue.
module id_operand_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        fs_to_ds_valid,
    input  logic [31:0] fs_pc,
    input  logic [31:0] fs_inst,
    output logic        ds_allowin,
    output logic [31:0] ds_pc,
    output logic [31:0] ds_inst,
    input  logic        src2_is_rd,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    input  logic        pause,
    input  logic        addr1_occur,
    input  logic [31:0] addr1_forward,
    input  logic        addr2_occur,
    input  logic [31:0] addr2_forward,
    input  logic        es_allowin,
    output logic        ds_to_es_valid,
    output logic [31:0] ds_src1,
    output logic [31:0] ds_src2,
    output logic [31:0] stall_cnt,
    output logic [1:0]  ds_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        load_inst;
    logic        load_lat;
    logic        ds_valid;
    logic        ds_ready_go;
    logic [31:0] live1;
    logic [31:0] live2;
    logic [31:0] lat1;
    logic [31:0] lat2;

    // Handshake: IF->DS moves when fs_to_ds_valid & ds_allowin; DS->EX moves when
    // ds_to_es_valid & es_allowin. Neither valid depends on the downstream ready.
    assign ds_valid       = (state != EMPTY);
    assign ds_ready_go    = ~pause;
    assign ds_to_es_valid = ds_valid & ds_ready_go & ~flush;
    assign ds_allowin     = ~ds_valid | (ds_ready_go & es_allowin);
    assign ds_state       = state;

    assign rf_raddr1 = ds_inst[9:5];
    assign rf_raddr2 = src2_is_rd ? ds_inst[4:0] : ds_inst[14:10];

    assign live1   = addr1_occur ? addr1_forward : rf_rdata1;
    assign live2   = addr2_occur ? addr2_forward : rf_rdata2;
    assign ds_src1 = (state == HELD) ? lat1 : live1;
    assign ds_src2 = (state == HELD) ? lat2 : live2;

    always_comb begin
        state_nxt = state;
        load_inst = 1'b0;
        load_lat  = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else if (ds_allowin && fs_to_ds_valid) begin
            state_nxt = FRESH;
            load_inst = 1'b1;
        end else if (ds_allowin) begin
            state_nxt = EMPTY;
        end else if (state == FRESH && !pause && !es_allowin) begin
            // Operands are resolved but EX is busy: freeze them before the bypass moves on.
            state_nxt = HELD;
            load_lat  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_pc   <= 32'h0;
            ds_inst <= 32'h0;
        end else if (load_inst) begin
            ds_pc   <= fs_pc;
            ds_inst <= fs_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat1 <= 32'h0;
            lat2 <= 32'h0;
        end else if (load_lat) begin
            lat1 <= live1;
            lat2 <= live2;
        end
    end

    // Flush leaves the count alone; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'h0;
        end else if (ds_valid && pause && !flush && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed scenarios plus a randomized run against a cycle-level
// reference model of the slot (occupied / operands-frozen / counter).
module tb_id_operand_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        ds_allowin;
  logic [31:0] ds_pc;
  logic [31:0] ds_inst;
  logic        src2_is_rd;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        pause;
  logic        addr1_occur;
  logic [31:0] addr1_forward;
  logic        addr2_occur;
  logic [31:0] addr2_forward;
  logic        es_allowin;
  logic        ds_to_es_valid;
  logic [31:0] ds_src1;
  logic [31:0] ds_src2;
  logic [31:0] stall_cnt;
  logic [1:0]  ds_state;

  int n_tests;
  int n_fails;

  id_operand_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc), .fs_inst(fs_inst),
    .ds_allowin(ds_allowin), .ds_pc(ds_pc), .ds_inst(ds_inst),
    .src2_is_rd(src2_is_rd), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .pause(pause), .addr1_occur(addr1_occur), .addr1_forward(addr1_forward),
    .addr2_occur(addr2_occur), .addr2_forward(addr2_forward),
    .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid),
    .ds_src1(ds_src1), .ds_src2(ds_src2), .stall_cnt(stall_cnt), .ds_state(ds_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change at posedge+1, checks happen at posedge+2
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; fs_to_ds_valid = 0; fs_pc = 0; fs_inst = 0; src2_is_rd = 0;
    rf_rdata1 = 0; rf_rdata2 = 0; pause = 0; addr1_occur = 0; addr1_forward = 0;
    addr2_occur = 0; addr2_forward = 0; es_allowin = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic load_inst(input logic [31:0] pc, input logic [31:0] inst);
    fs_to_ds_valid = 1; fs_pc = pc; fs_inst = inst;
    step();
    fs_to_ds_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    fs_to_ds_valid = 1; fs_pc = 32'h1000; fs_inst = 32'hFFFF_FFFF; pause = 1;
    reset = 1;
    step();
    step();
    src2_is_rd = 1;
    #1;
    n_tests++; if (ds_to_es_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got=%b exp=0", ds_to_es_valid); end
    n_tests++; if (ds_allowin !== 1'b1) begin n_fails++; $display("FAIL reset_allowin got=%b exp=1", ds_allowin); end
    n_tests++; if (stall_cnt !== 32'h0) begin n_fails++; $display("FAIL reset_cnt got=%h exp=0", stall_cnt); end
    n_tests++; if (ds_pc !== 32'h0 || ds_inst !== 32'h0) begin n_fails++; $display("FAIL reset_pc_inst got=%h/%h exp=0/0", ds_pc, ds_inst); end
    n_tests++; if (rf_raddr1 !== 5'd0 || rf_raddr2 !== 5'd0) begin n_fails++; $display("FAIL reset_raddr got=%0d/%0d exp=0/0", rf_raddr1, rf_raddr2); end
    n_tests++; if (ds_state !== 2'd0) begin n_fails++; $display("FAIL reset_state got=%0d exp=0", ds_state); end
    reset = 0;
    idle_inputs();
  endtask

  task automatic test_stream();
    logic [31:0] pcs[3];
    logic [31:0] insts[3];
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  exp_r2;
    do_reset();
    es_allowin = 1;
    for (int i = 0; i < 3; i++) begin
      pcs[i] = 32'h1c00_0000 + 32'(i * 4);
      insts[i] = $urandom;
    end
    for (int c = 0; c < 5; c++) begin
      fs_to_ds_valid = (c < 3);
      fs_pc = (c < 3) ? pcs[c] : 32'h0;
      fs_inst = (c < 3) ? insts[c] : 32'h0;
      d1 = $urandom; d2 = $urandom;
      rf_rdata1 = d1; rf_rdata2 = d2;
      src2_is_rd = c[0];
      #1;
      if (c >= 1 && c <= 3) begin
        exp_r2 = c[0] ? insts[c-1][4:0] : insts[c-1][14:10];
        n_tests++; if (ds_to_es_valid !== 1'b1) begin n_fails++; $display("FAIL stream_valid[%0d] got=%b exp=1", c, ds_to_es_valid); end
        n_tests++; if (ds_pc !== pcs[c-1]) begin n_fails++; $display("FAIL stream_pc[%0d] got=%h exp=%h", c, ds_pc, pcs[c-1]); end
        n_tests++; if (ds_src1 !== d1 || ds_src2 !== d2) begin n_fails++; $display("FAIL stream_src[%0d] got=%h/%h exp=%h/%h", c, ds_src1, ds_src2, d1, d2); end
        n_tests++; if (rf_raddr1 !== insts[c-1][9:5] || rf_raddr2 !== exp_r2) begin n_fails++; $display("FAIL stream_raddr[%0d] got=%0d/%0d exp=%0d/%0d", c, rf_raddr1, rf_raddr2, insts[c-1][9:5], exp_r2); end
      end else begin
        n_tests++; if (ds_to_es_valid !== 1'b0) begin n_fails++; $display("FAIL stream_idle[%0d] got=%b exp=0", c, ds_to_es_valid); end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_forward();
    do_reset();
    load_inst(32'h200, 32'h0000_1234);
    es_allowin = 1;
    addr1_occur = 1; addr1_forward = 32'hDEAD_BEEF; rf_rdata1 = 32'h1234;
    addr2_occur = 0; addr2_forward = 32'h7777_7777; rf_rdata2 = 32'h55;
    #1;
    n_tests++; if (ds_src1 !== 32'hDEAD_BEEF) begin n_fails++; $display("FAIL fwd_src1 got=%h exp=deadbeef", ds_src1); end
    n_tests++; if (ds_src2 !== 32'h55) begin n_fails++; $display("FAIL fwd_src2_rf got=%h exp=55", ds_src2); end
    addr1_occur = 0; addr2_occur = 1;
    #1;
    n_tests++; if (ds_src1 !== 32'h1234 || ds_src2 !== 32'h7777_7777) begin n_fails++; $display("FAIL fwd_port2 got=%h/%h exp=1234/77777777", ds_src1, ds_src2); end
    step();
    idle_inputs();
  endtask

  task automatic test_pause();
    do_reset();
    load_inst(32'h300, 32'hABCD_0000);
    es_allowin = 1; pause = 1;
    fs_to_ds_valid = 1; fs_pc = 32'h304; fs_inst = 32'h1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_tests++; if (ds_to_es_valid !== 1'b0 || ds_allowin !== 1'b0) begin n_fails++; $display("FAIL pause_block[%0d] got=%b/%b exp=0/0", c, ds_to_es_valid, ds_allowin); end
      step();
    end
    pause = 0; fs_to_ds_valid = 0;
    #1;
    n_tests++; if (ds_to_es_valid !== 1'b1 || ds_pc !== 32'h300) begin n_fails++; $display("FAIL pause_issue got=%b/%h exp=1/300", ds_to_es_valid, ds_pc); end
    n_tests++; if (stall_cnt !== 32'd3) begin n_fails++; $display("FAIL pause_cnt got=%0d exp=3", stall_cnt); end
    step();
    n_tests++; if (ds_state !== 2'd0 || stall_cnt !== 32'd3) begin n_fails++; $display("FAIL pause_after got=%0d/%0d exp=0/3", ds_state, stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    load_inst(32'h400, 32'h0);
    es_allowin = 0;
    rf_rdata1 = 32'hA5A5_0001; rf_rdata2 = 32'h0000_0002;
    step();
    rf_rdata1 = 0; rf_rdata2 = 0;
    addr1_occur = 1; addr1_forward = 0; addr2_occur = 1; addr2_forward = 0;
    for (int c = 0; c < 3; c++) begin
      pause = (c == 1);
      #1;
      n_tests++; if (ds_src1 !== 32'hA5A5_0001 || ds_src2 !== 32'h2) begin n_fails++; $display("FAIL bp_hold[%0d] got=%h/%h exp=a5a50001/2", c, ds_src1, ds_src2); end
      n_tests++; if (ds_allowin !== 1'b0 || ds_to_es_valid !== (c != 1)) begin n_fails++; $display("FAIL bp_hs[%0d] got=%b/%b", c, ds_allowin, ds_to_es_valid); end
      step();
    end
    pause = 0; es_allowin = 1;
    #1;
    n_tests++; if (ds_to_es_valid !== 1'b1 || ds_src1 !== 32'hA5A5_0001 || ds_src2 !== 32'h2) begin n_fails++; $display("FAIL bp_issue got=%b %h/%h exp=1 a5a50001/2", ds_to_es_valid, ds_src1, ds_src2); end
    step();
    n_tests++; if (ds_state !== 2'd0) begin n_fails++; $display("FAIL bp_empty got=%0d exp=0", ds_state); end
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    load_inst(32'h500, 32'h5);
    es_allowin = 1; pause = 1;
    step();
    fs_to_ds_valid = 1; fs_pc = 32'h504; fs_inst = 32'h6; flush = 1;
    #1;
    n_tests++; if (ds_to_es_valid !== 1'b0) begin n_fails++; $display("FAIL flush_valid got=%b exp=0", ds_to_es_valid); end
    step();
    flush = 0; fs_to_ds_valid = 0; pause = 0;
    #1;
    n_tests++; if (ds_state !== 2'd0 || ds_to_es_valid !== 1'b0) begin n_fails++; $display("FAIL flush_empty got=%0d/%b exp=0/0", ds_state, ds_to_es_valid); end
    n_tests++; if (ds_pc !== 32'h500 || ds_inst !== 32'h5) begin n_fails++; $display("FAIL flush_noload got=%h/%h exp=500/5", ds_pc, ds_inst); end
    n_tests++; if (stall_cnt !== 32'd1) begin n_fails++; $display("FAIL flush_cnt got=%0d exp=1", stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    load_inst(32'h600, 32'h0);
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    pause = 1; es_allowin = 1;
    #1;
    n_tests++; if (stall_cnt !== 32'hFFFF_FFFE) begin n_fails++; $display("FAIL sat_preset got=%h exp=fffffffe", stall_cnt); end
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++; if (stall_cnt !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL sat_cnt[%0d] got=%h exp=ffffffff", c, stall_cnt); end
    end
    idle_inputs();
    do_reset();
  endtask

  task automatic test_random();
    bit          m_full;
    bit          m_frozen;
    logic [31:0] m_pc, m_inst, m_op1, m_op2, m_cnt;
    logic [31:0] live1, live2, e_src1, e_src2;
    logic        e_valid, e_allow;
    logic [4:0]  e_r1, e_r2;
    do_reset();
    m_full = 0; m_frozen = 0; m_pc = 0; m_inst = 0; m_op1 = 0; m_op2 = 0; m_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(0, 15) == 0);
      pause = ($urandom_range(0, 3) == 0);
      es_allowin = ($urandom_range(0, 3) != 0);
      fs_to_ds_valid = ($urandom_range(0, 3) != 0);
      fs_pc = $urandom; fs_inst = $urandom; src2_is_rd = 1'($urandom_range(0, 1));
      rf_rdata1 = $urandom; rf_rdata2 = $urandom;
      addr1_occur = 1'($urandom_range(0, 1)); addr1_forward = $urandom;
      addr2_occur = 1'($urandom_range(0, 1)); addr2_forward = $urandom;
      #1;
      live1 = addr1_occur ? addr1_forward : rf_rdata1;
      live2 = addr2_occur ? addr2_forward : rf_rdata2;
      e_src1 = m_frozen ? m_op1 : live1;
      e_src2 = m_frozen ? m_op2 : live2;
      e_valid = m_full && !pause && !flush;
      e_allow = !m_full || (!pause && es_allowin);
      e_r1 = m_inst[9:5];
      e_r2 = src2_is_rd ? m_inst[4:0] : m_inst[14:10];
      n_tests++; if (ds_to_es_valid !== e_valid || ds_allowin !== e_allow) begin n_fails++; $display("FAIL rnd_hs[%0d] got=%b/%b exp=%b/%b", c, ds_to_es_valid, ds_allowin, e_valid, e_allow); end
      n_tests++; if (ds_src1 !== e_src1 || ds_src2 !== e_src2) begin n_fails++; $display("FAIL rnd_src[%0d] got=%h/%h exp=%h/%h", c, ds_src1, ds_src2, e_src1, e_src2); end
      n_tests++; if (ds_pc !== m_pc || ds_inst !== m_inst) begin n_fails++; $display("FAIL rnd_buf[%0d] got=%h/%h exp=%h/%h", c, ds_pc, ds_inst, m_pc, m_inst); end
      n_tests++; if (rf_raddr1 !== e_r1 || rf_raddr2 !== e_r2) begin n_fails++; $display("FAIL rnd_raddr[%0d] got=%0d/%0d exp=%0d/%0d", c, rf_raddr1, rf_raddr2, e_r1, e_r2); end
      n_tests++; if (stall_cnt !== m_cnt) begin n_fails++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", c, stall_cnt, m_cnt); end
      // advance the reference model to what the next cycle should hold
      if (m_full && pause && !flush && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (flush) begin
        m_full = 0; m_frozen = 0;
      end else if (e_allow && fs_to_ds_valid) begin
        m_full = 1; m_frozen = 0; m_pc = fs_pc; m_inst = fs_inst;
      end else if (e_allow) begin
        m_full = 0; m_frozen = 0;
      end else if (m_full && !m_frozen && !pause && !es_allowin) begin
        m_frozen = 1; m_op1 = live1; m_op2 = live2;
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fails = 0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_stream();
    test_forward();
    test_pause();
    test_backpressure();
    test_flush();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Decode-stage pipeline slot that sits directly upstream of the EX stage and directly consumes the data-hazard detector's outputs. It does four things:
- buffers the instruction handed over by IF;
- drives the register-file and hazard-detector read addresses;
- merges forwarded values over register-file data;
- holds the instruction while `pause` is asserted.

Once operands are resolved, it latches them so they stay stable while EX back-pressures. It also keeps a saturating hazard-stall counter for performance analysis.

## Interface
Parameters:
- none

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `flush` in 1 — exception/ertn flush; kills the instruction held in this stage.
- `fs_to_ds_valid` in 1 — IF has an instruction to hand over.
- `fs_pc` in 32 — PC of the IF instruction.
- `fs_inst` in 32 — encoding of the IF instruction.
- `ds_allowin` out 1 — this stage accepts from IF this cycle.
- `ds_pc` out 32 — buffered PC.
- `ds_inst` out 32 — buffered instruction, fed to the combinational decoder.
- `src2_is_rd` in 1 — from the decoder: second source is rd (`inst[4:0]`) rather than rk (`inst[14:10]`).
- `rf_raddr1` out 5 — always `ds_inst[9:5]` (rj). Drives both the register file and the hazard detector.
- `rf_raddr2` out 5 — `src2_is_rd ? ds_inst[4:0] : ds_inst[14:10]`.
- `rf_rdata1` in 32 — register-file data for port 1.
- `rf_rdata2` in 32 — register-file data for port 2.
- `pause` in 1 — hazard stall from the hazard detector.
- `addr1_occur` in 1 — hazard hit on port 1.
- `addr1_forward` in 32 — forwarded value for port 1.
- `addr2_occur` in 1 — hazard hit on port 2.
- `addr2_forward` in 32 — forwarded value for port 2.
- `es_allowin` in 1 — EX accepts this cycle.
- `ds_to_es_valid` out 1 — instruction and operands are valid toward EX.
- `ds_src1` out 32 — resolved operand 1.
- `ds_src2` out 32 — resolved operand 2.
- `stall_cnt` out 32 — number of cycles stalled by `pause`.

## Operation
State machine (2-bit register):
- **EMPTY** — no instruction held.
- **FRESH** — instruction held; operands taken live from the mux.
- **HELD** — instruction held; operands taken from the internal latches.

Live operand mux:
- `live1 = addr1_occur ? addr1_forward : rf_rdata1`.
- `live2` is formed the same way from port 2.
- `ds_src1/2 = (state==HELD) ? lat1/2 : live1/2`.

Handshake:
- `ds_ready_go = ~pause`, in every state.
- `ds_valid = (state != EMPTY)`.
- `ds_to_es_valid = ds_valid & ds_ready_go & ~flush`.
- `ds_allowin = ~ds_valid | (ds_ready_go & es_allowin)`.
- A transfer to EX occurs when `ds_to_es_valid & es_allowin`.

Transitions, priority order:
1. `reset`: go to EMPTY. Clear `ds_pc`, `ds_inst`, `lat1`, `lat2` and `stall_cnt` to 0.
2. `flush`: go to EMPTY. IF input is ignored in the same cycle.
3. `ds_allowin & fs_to_ds_valid`: go to FRESH and load `ds_pc`/`ds_inst` from IF. This covers both simultaneous hand-off (EX takes the old instruction, IF loads the new one) and the EMPTY case.
4. `ds_allowin & ~fs_to_ds_valid`: go to EMPTY.
5. In FRESH with `~pause & ~es_allowin`: go to HELD and load `lat1 <= live1`, `lat2 <= live2`.
6. Otherwise hold the current state. In HELD, the latches do not change even if `pause` reasserts. A reasserted `pause` still blocks issue.

Stall counter:
- `stall_cnt` increments when `ds_valid & pause & ~flush`.
- It saturates at `32'hFFFF_FFFF`.
- Only `reset` clears it; `flush` does not.

## Timing
- Decode latency is 1 cycle: an instruction accepted at edge N may issue at edge N+1 if `pause=0` and `es_allowin=1`.
- `ds_src*`, `ds_to_es_valid` and `ds_allowin` are combinational from the current state and inputs.
- `rf_raddr*` are combinational from `ds_inst` and `src2_is_rd`.
- Operands are latched only on the edge that leaves FRESH for HELD. From then on, EX sees stable values even after the producer retires and the bypass buses change.
- Output values after reset:
  - `ds_to_es_valid=0`, `ds_allowin=1`, `stall_cnt=0`.
  - `ds_pc=0` and `ds_inst=0`, so `rf_raddr1=0`; `rf_raddr2=0` regardless of `src2_is_rd`.
- Back-to-back issue is supported: one instruction per cycle when there are no stalls.
- Reset mid-stall: the stage is in EMPTY on the next cycle, and the held instruction is dropped without issuing.

## Test plan
- **Stream with no hazards.** After reset, IF supplies 3 instructions on consecutive cycles with `es_allowin=1` and `pause=0`.
  - Required: `ds_to_es_valid=1` on 3 consecutive cycles with matching PCs and `ds_src = rf_rdata`.
- **Forwarding override.** `addr1_occur=1`, `addr1_forward=32'hDEAD_BEEF`, `rf_rdata1=32'h1234`.
  - Required: `ds_src1=32'hDEAD_BEEF`.
- **Pause stall.** `pause=1` for 3 cycles while an instruction is held.
  - Required: `ds_to_es_valid=0` and `ds_allowin=0` for those 3 cycles.
  - Required: `stall_cnt` advances by exactly 3.
  - Required: the instruction issues on the cycle `pause` drops.
- **EX back-pressure latch.** Operands resolve to `32'hA5A5_0001`/`32'h0000_0002`; hold `es_allowin=0` for 4 cycles while the bypass and `rf_rdata` inputs change to `32'h0`.
  - Required: on the issue cycle, `ds_src1/2` still equal `32'hA5A5_0001`/`32'h0000_0002`.
- **Flush.** Assert `flush` during a paused stall with `fs_to_ds_valid=1`.
  - Required: `ds_to_es_valid=0` in that cycle and state EMPTY on the next cycle.
  - Required: the IF instruction is not loaded.
  - Required: `stall_cnt` is unchanged in the flush cycle.
- **Counter saturation.** Force `stall_cnt` to `32'hFFFF_FFFE` and stall for 3 cycles.
  - Required: `stall_cnt` reads `32'hFFFF_FFFF` and stays there.
